projectile_ctrl: RTL and testbench
==================================

PROJECTILE_CTRL -- requirements
Module: projectile_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- COOLDOWN_FRAMES, 30, frames a channel stays in COOL after a shot ends.
- HIT_W, 40, hitbox width in pixels starting at target SpriteX.
- X_MAX, 630, ball X above this is out of bounds.
- DAMAGE, 10, health removed per hit.
- GRACE, 2, initial FLY frames with hit/bounds checks suppressed.

REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- frame_clk, in, 1: the single clock; all logic is rising-edge, one frame per cycle.
- Reset, in, 1: synchronous, active-high reset.
- startscreen, in, 1: match not running.
- shoot, in, 1: player-1 fire request (level).
- shoot2, in, 1: player-2 fire request (level).
- SpriteX, in, 10: player-1 sprite left X.
- SpriteX2, in, 10: player-2 sprite left X.
- BallX, in, 10: player-1 projectile X from the projectile mover.
- BallX2, in, 10: player-2 projectile X from the projectile mover.
- flying, out, 1: player-1 projectile in flight; drives the mover.
- flying2, out, 1: player-2 projectile in flight; drives the mover.
- ballcollision, out, 1: one-cycle pulse when the player-1 ball hits player 2.
- ballcollision2, out, 1: one-cycle pulse when the player-2 ball hits player 1.
- Health, out, 7: player-1 health, 0..100.
- Health2, out, 7: player-2 health, 0..100.
- ko, out, 1: either health is 0.
- winner, out, 2: 00 none, 01 player 1, 10 player 2, 11 double KO.

Function
REQ-003 Each player SHALL own one channel FSM with states IDLE, FLY, COOL. Channel 1 is the shooter=player 1, BallX, target SpriteX2. Channel 2 is the mirror.
REQ-004 The channel SHALL register shoot each cycle. A fire event is shoot=1 while the previous sample was 0. Holding shoot high SHALL never refire.
REQ-005 IDLE -> FLY on a fire event when startscreen=0 and ko=0. flying SHALL be 1 from the cycle after the event.
REQ-006 In FLY, a frame counter SHALL count from 0. While the counter < GRACE, no hit or bounds check SHALL occur.
REQ-007 In FLY after grace, a hit SHALL be detected when target SpriteX <= ball X <= target SpriteX+HIT_W-1, using 11-bit unsigned compare with no wrap. A hit SHALL pulse ballcollision for exactly 1 cycle, subtract DAMAGE from the target health, and go to COOL.
REQ-008 In FLY after grace, ball X > X_MAX SHALL go to COOL with no pulse. This includes leftward wrap, where X reads near 1023.
REQ-009 If hit and out-of-bounds conditions coincide, the hit SHALL take priority.
REQ-010 COOL SHALL hold flying=0 for COOLDOWN_FRAMES cycles, then go to IDLE. Fire events during COOL SHALL be discarded, not queued.
REQ-011 Health update SHALL saturate: if health <= DAMAGE, the new value is 0, never negative.
REQ-012 If both channels hit in the same cycle, both pulses SHALL fire and both healths SHALL decrement in that cycle.
REQ-013 ko and winner SHALL be registered from the health values, with 1-cycle latency after the health update.
REQ-014 While ko=1, channels in FLY SHALL go to IDLE next cycle with no pulse, and no new FLY SHALL start.
REQ-015 startscreen=1 SHALL act as a match reset: channels to IDLE, counters 0, health to 100, ko and winner cleared. The shoot edge registers SHALL still sample, so a shoot held across the startscreen falling edge does not fire.

Reset
REQ-016 On Reset=1 at a frame_clk edge, the block SHALL take these values: flying=0, flying2=0, ballcollision=0, ballcollision2=0, Health=100, Health2=100, ko=0, winner=00, FSMs IDLE, counters 0, shoot edge registers 0.
REQ-017 Reset asserted mid-flight SHALL take effect at the next edge and override every other input.

Structure
REQ-018 A shared package game_pkg SHALL hold the channel state enum, HEALTH_MAX=100, and the winner encodings.
REQ-019 The block SHALL instantiate sub-module proj_chan twice. proj_chan holds the edge detector, FSM, grace/cooldown counter and hit/bounds compare. Health, ko and winner logic SHALL reside in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then shoot pulse with SpriteX2=300 and BallX stepping 60,65,...: flying=1 one cycle after the edge; ballcollision pulses once at BallX=300; Health2=90; 30 COOL cycles, then IDLE.
- shoot held high for 200 frames: exactly one FLY entry.
- BallX2 stepping down 8,3,1022: no pulse; COOL entered at BallX2=1022.
- Both balls hit in the same cycle with Health=Health2=10: both pulses fire; both healths 0; next cycle ko=1, winner=11.
- Health2=5 and a hit: Health2 saturates at 0; winner=01; a subsequent shoot is ignored.
- Reset asserted while in FLY: flying=0 and Health=100 at the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: projectile channel states, health limits,
// winner encodings and the saturating health update.
package game_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_FLY  = 2'd1,
    CH_COOL = 2'd2
  } chan_state_t;

  localparam logic [6:0] HEALTH_MAX = 7'd100;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_BOTH = 2'b11;

  // Shared width for the grace and cooldown frame counter.
  localparam int CNT_W = 16;

  // A hit never drives health negative: anything at or below the damage
  // amount lands on zero.
  function automatic logic [6:0] health_after_hit(input logic [6:0] health,
                                                  input logic [6:0] damage);
    if (health <= damage) begin
      return 7'd0;
    end else begin
      return health - damage;
    end
  endfunction

endpackage

// File: rtl/proj_chan.sv
// One player's projectile channel: fire edge detector, IDLE/FLY/COOL
// state machine, shared grace/cooldown counter and hitbox/bounds compare.
module proj_chan
  import game_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int HIT_W           = 40,
  parameter int X_MAX           = 630,
  parameter int GRACE           = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       startscreen,
  input  logic       ko,
  input  logic       shoot,
  input  logic [9:0] ball_x,
  input  logic [9:0] target_x,
  output logic       flying,
  output logic       hit
);

  chan_state_t state, state_next;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_next;
  logic shoot_q;
  logic fire;
  logic in_grace;
  logic in_hitbox;
  logic out_of_bounds;
  logic [10:0] ball_x11;
  logic [10:0] hit_lo;
  logic [10:0] hit_hi;

  // Widening to 11 bits keeps a hitbox near the right edge from wrapping.
  assign ball_x11      = {1'b0, ball_x};
  assign hit_lo        = {1'b0, target_x};
  assign hit_hi        = hit_lo + 11'(HIT_W - 1);
  assign in_hitbox     = (ball_x11 >= hit_lo) && (ball_x11 <= hit_hi);
  assign out_of_bounds = ball_x11 > 11'(X_MAX);
  assign in_grace      = frame_cnt < CNT_W'(GRACE);
  assign fire          = shoot & ~shoot_q;
  assign flying        = (state == CH_FLY);

  // Previous shoot sample; keeps running through startscreen so a held
  // button cannot fire when the match begins.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      shoot_q <= 1'b0;
    end else begin
      shoot_q <= shoot;
    end
  end

  // State and frame counter registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= CH_IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
    end
  end

  // Next-state logic; a hit outranks leaving the screen, and ko ends any flight.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    hit            = 1'b0;
    if (startscreen) begin
      state_next     = CH_IDLE;
      frame_cnt_next = '0;
    end else begin
      unique case (state)
        CH_IDLE: begin
          if (fire && !ko) begin
            state_next     = CH_FLY;
            frame_cnt_next = '0;
          end
        end
        CH_FLY: begin
          if (ko) begin
            state_next     = CH_IDLE;
            frame_cnt_next = '0;
          end else if (in_grace) begin
            frame_cnt_next = frame_cnt + CNT_W'(1);
          end else if (in_hitbox) begin
            hit            = 1'b1;
            state_next     = CH_COOL;
            frame_cnt_next = '0;
          end else if (out_of_bounds) begin
            state_next     = CH_COOL;
            frame_cnt_next = '0;
          end
        end
        CH_COOL: begin
          if (frame_cnt >= CNT_W'(COOLDOWN_FRAMES - 1)) begin
            state_next     = CH_IDLE;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next     = CH_IDLE;
          frame_cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/projectile_ctrl.sv
// Two-player projectile controller: one proj_chan per player, plus the
// health bookkeeping, collision pulses and ko/winner flags.
module projectile_ctrl
  import game_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int HIT_W           = 40,
  parameter int X_MAX           = 630,
  parameter int DAMAGE          = 10,
  parameter int GRACE           = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       startscreen,
  input  logic       shoot,
  input  logic       shoot2,
  input  logic [9:0] SpriteX,
  input  logic [9:0] SpriteX2,
  input  logic [9:0] BallX,
  input  logic [9:0] BallX2,
  output logic       flying,
  output logic       flying2,
  output logic       ballcollision,
  output logic       ballcollision2,
  output logic [6:0] Health,
  output logic [6:0] Health2,
  output logic       ko,
  output logic [1:0] winner
);

  localparam logic [6:0] DMG = 7'(DAMAGE);

  logic hit1;
  logic hit2;

  proj_chan #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
    .HIT_W          (HIT_W),
    .X_MAX          (X_MAX),
    .GRACE          (GRACE)
  ) u_chan1 (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .startscreen(startscreen),
    .ko         (ko),
    .shoot      (shoot),
    .ball_x     (BallX),
    .target_x   (SpriteX2),
    .flying     (flying),
    .hit        (hit1)
  );

  proj_chan #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
    .HIT_W          (HIT_W),
    .X_MAX          (X_MAX),
    .GRACE          (GRACE)
  ) u_chan2 (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .startscreen(startscreen),
    .ko         (ko),
    .shoot      (shoot2),
    .ball_x     (BallX2),
    .target_x   (SpriteX),
    .flying     (flying2),
    .hit        (hit2)
  );

  // Collision pulses and health land together; both sides can be hit at once.
  always_ff @(posedge frame_clk) begin
    if (Reset || startscreen) begin
      Health         <= HEALTH_MAX;
      Health2        <= HEALTH_MAX;
      ballcollision  <= 1'b0;
      ballcollision2 <= 1'b0;
    end else begin
      ballcollision  <= hit1;
      ballcollision2 <= hit2;
      if (hit1) begin
        Health2 <= health_after_hit(Health2, DMG);
      end
      if (hit2) begin
        Health <= health_after_hit(Health, DMG);
      end
    end
  end

  // ko and winner trail the registered health values by one frame.
  always_ff @(posedge frame_clk) begin
    if (Reset || startscreen) begin
      ko     <= 1'b0;
      winner <= WIN_NONE;
    end else begin
      ko <= (Health == 7'd0) || (Health2 == 7'd0);
      case ({Health == 7'd0, Health2 == 7'd0})
        2'b01:   winner <= WIN_P1;
        2'b10:   winner <= WIN_P2;
        2'b11:   winner <= WIN_BOTH;
        default: winner <= WIN_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_ctrl.sv
// Self-checking bench for projectile_ctrl: directed scenarios with literal
// expectations, then randomized play checked every frame against a
// behavioural model of the game rules.
`timescale 1ns/1ps
module tb_projectile_ctrl;

  localparam int COOLDOWN = 30;
  localparam int HITW     = 40;
  localparam int XMAX     = 630;
  localparam int DMG      = 10;
  localparam int GRACE_F  = 2;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       startscreen;
  logic       shoot;
  logic       shoot2;
  logic [9:0] SpriteX;
  logic [9:0] SpriteX2;
  logic [9:0] BallX;
  logic [9:0] BallX2;
  logic       flying;
  logic       flying2;
  logic       ballcollision;
  logic       ballcollision2;
  logic [6:0] Health;
  logic [6:0] Health2;
  logic       ko;
  logic [1:0] winner;

  logic       b_flying;
  logic       b_flying2;
  logic       b_bc;
  logic       b_bc2;
  logic [6:0] b_h;
  logic [6:0] b_h2;
  logic       b_ko;
  logic [1:0] b_win;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  projectile_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .startscreen   (startscreen),
    .shoot         (shoot),
    .shoot2        (shoot2),
    .SpriteX       (SpriteX),
    .SpriteX2      (SpriteX2),
    .BallX         (BallX),
    .BallX2        (BallX2),
    .flying        (flying),
    .flying2       (flying2),
    .ballcollision (ballcollision),
    .ballcollision2(ballcollision2),
    .Health        (Health),
    .Health2       (Health2),
    .ko            (ko),
    .winner        (winner)
  );

  // Second copy with a larger damage so health can reach 5 before the final hit.
  projectile_ctrl #(.DAMAGE(19)) dut19 (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .startscreen   (startscreen),
    .shoot         (shoot),
    .shoot2        (shoot2),
    .SpriteX       (SpriteX),
    .SpriteX2      (SpriteX2),
    .BallX         (BallX),
    .BallX2        (BallX2),
    .flying        (b_flying),
    .flying2       (b_flying2),
    .ballcollision (b_bc),
    .ballcollision2(b_bc2),
    .Health        (b_h),
    .Health2       (b_h2),
    .ko            (b_ko),
    .winner        (b_win)
  );

  // Behavioural model state: index 0 is player 1, index 1 is player 2.
  bit         model_valid = 1'b0;
  bit         m_prev[2];
  bit         m_fly[2];
  int         m_age[2];
  int         m_cool[2];
  bit         m_hit[2];
  int         m_hp[2];
  bit         m_ko;
  logic [1:0] m_win;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("flying",         flying,         m_fly[0]);
    checkValue("flying2",        flying2,        m_fly[1]);
    checkValue("ballcollision",  ballcollision,  m_hit[0]);
    checkValue("ballcollision2", ballcollision2, m_hit[1]);
    checkValue("Health",         Health,         m_hp[0]);
    checkValue("Health2",        Health2,        m_hp[1]);
    checkValue("ko",             ko,             m_ko);
    checkValue("winner",         winner,         m_win);
  endtask

  // Game rules applied once per frame to the inputs seen at the edge.
  always @(posedge frame_clk) begin : model
    bit sh[2];
    int bx[2];
    int tx[2];
    int hp_old[2];
    bit ko_old;
    bit fire;
    sh[0] = shoot;   sh[1] = shoot2;
    bx[0] = BallX;   bx[1] = BallX2;
    tx[0] = SpriteX2; tx[1] = SpriteX;
    if (Reset === 1'b1) begin
      for (int c = 0; c < 2; c++) begin
        m_prev[c] = 1'b0; m_fly[c] = 1'b0; m_age[c] = 0;
        m_cool[c] = 0;    m_hit[c] = 1'b0; m_hp[c] = 100;
      end
      m_ko = 1'b0;
      m_win = 2'b00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      hp_old = m_hp;
      ko_old = m_ko;
      if (startscreen) begin
        for (int c = 0; c < 2; c++) begin
          m_fly[c] = 1'b0; m_cool[c] = 0; m_hit[c] = 1'b0; m_hp[c] = 100;
        end
        m_ko = 1'b0;
        m_win = 2'b00;
      end else begin
        for (int c = 0; c < 2; c++) begin
          m_hit[c] = 1'b0;
          fire = sh[c] && !m_prev[c];
          if (m_fly[c]) begin
            if (ko_old) begin
              m_fly[c] = 1'b0;
            end else if (m_age[c] < GRACE_F) begin
              m_age[c]++;
            end else if (bx[c] >= tx[c] && bx[c] < tx[c] + HITW) begin
              m_hit[c] = 1'b1; m_fly[c] = 1'b0; m_cool[c] = COOLDOWN;
            end else if (bx[c] > XMAX) begin
              m_fly[c] = 1'b0; m_cool[c] = COOLDOWN;
            end
          end else if (m_cool[c] > 0) begin
            m_cool[c]--;
          end else if (fire && !ko_old) begin
            m_fly[c] = 1'b1; m_age[c] = 0;
          end
        end
        for (int c = 0; c < 2; c++) begin
          if (m_hit[c]) m_hp[1-c] = (m_hp[1-c] <= DMG) ? 0 : m_hp[1-c] - DMG;
        end
        m_ko  = (hp_old[0] == 0) || (hp_old[1] == 0);
        m_win = {hp_old[0] == 0, hp_old[1] == 0};
      end
      m_prev = sh;
    end
  end

  // Compare the DUT against the model on every falling edge once reset has been seen.
  always @(negedge frame_clk) begin
    if (model_valid) checkOutput();
  end

  task automatic step();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic applyStimulus(input bit s1, input bit s2, input logic [9:0] bx1, input logic [9:0] bx2);
    shoot = s1; shoot2 = s2; BallX = bx1; BallX2 = bx2;
    step();
  endtask

  task automatic doReset();
    Reset = 1'b1; startscreen = 1'b0; shoot = 1'b0; shoot2 = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  // Fire the selected channels and advance to the frame where a hit would show.
  task automatic volley(input bit p1, input bit p2);
    applyStimulus(p1, p2, BallX, BallX2);
    applyStimulus(1'b0, 1'b0, BallX, BallX2);
    step();
    step();
  endtask

  task automatic coolDown();
    repeat (COOLDOWN) step();
  endtask

  function automatic logic [9:0] pickBall(input logic [9:0] tgt);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4)       return 10'(int'(tgt) + int'($urandom_range(0, 50)) - 5);
    else if (r == 4) return 10'($urandom_range(0, 1023));
    else if (r == 5) return 10'($urandom_range(600, 660));
    else             return 10'($urandom_range(0, 630));
  endfunction

  initial begin
    int pulses;
    int hitx;
    int rises;
    bit prevf;

    Reset = 1'b1; startscreen = 1'b0; shoot = 1'b0; shoot2 = 1'b0;
    SpriteX = 10'd500; SpriteX2 = 10'd300; BallX = 10'd60; BallX2 = 10'd0;

    // Reset state and first shot with a hit at 300
    doReset();
    checkValue("rst_flying", flying, 0);
    checkValue("rst_Health", Health, 100);
    checkValue("rst_Health2", Health2, 100);
    checkValue("rst_winner", winner, 0);
    checkValue("rst_b_Health2", b_h2, 100);
    shoot = 1'b1;
    step();
    checkValue("s1_flying_after_edge", flying, 1);
    shoot = 1'b0;
    pulses = 0;
    hitx = -1;
    for (int x = 60; x <= 400 && pulses == 0; x += 5) begin
      BallX = 10'(x);
      step();
      if (ballcollision) begin pulses++; hitx = x; end
    end
    checkValue("s1_hit_x", hitx, 300);
    checkValue("s1_Health2", Health2, 90);
    checkValue("s1_flying_cool", flying, 0);
    BallX = 10'd800;
    repeat (28) begin
      step();
      if (ballcollision) pulses++;
    end
    shoot = 1'b1;
    step();
    checkValue("s1_fire_in_cool_dropped", flying, 0);
    shoot = 1'b0;
    step();
    shoot = 1'b1;
    step();
    checkValue("s1_fire_after_cool", flying, 1);
    checkValue("s1_pulse_count", pulses, 1);

    // Held shoot fires once
    doReset();
    BallX = 10'd700;
    rises = 0;
    prevf = flying;
    repeat (200) begin
      shoot = 1'b1;
      step();
      if (flying && !prevf) rises++;
      prevf = flying;
    end
    checkValue("s2_fly_entries", rises, 1);

    // Leftward wrap ends the player-2 flight without a pulse
    doReset();
    SpriteX = 10'd500;
    pulses = 0;
    applyStimulus(1'b0, 1'b1, 10'd0, 10'd18);
    checkValue("s3_flying2_start", flying2, 1);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd18);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd13);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd8);
    if (ballcollision2) pulses++;
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd3);
    if (ballcollision2) pulses++;
    checkValue("s3_flying2_at_3", flying2, 1);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd1022);
    if (ballcollision2) pulses++;
    checkValue("s3_flying2_wrap", flying2, 0);
    applyStimulus(1'b0, 1'b1, 10'd0, 10'd1022);
    if (ballcollision2) pulses++;
    checkValue("s3_cool_refire_dropped", flying2, 0);
    checkValue("s3_no_pulse", pulses, 0);

    // Simultaneous hits down to a double KO
    doReset();
    SpriteX = 10'd100; SpriteX2 = 10'd400; BallX = 10'd410; BallX2 = 10'd110;
    repeat (9) begin
      volley(1'b1, 1'b1);
      coolDown();
    end
    checkValue("s4_Health_10", Health, 10);
    checkValue("s4_Health2_10", Health2, 10);
    volley(1'b1, 1'b1);
    checkValue("s4_pulse1", ballcollision, 1);
    checkValue("s4_pulse2", ballcollision2, 1);
    checkValue("s4_Health_0", Health, 0);
    checkValue("s4_Health2_0", Health2, 0);
    checkValue("s4_ko_lag", ko, 0);
    step();
    checkValue("s4_ko", ko, 1);
    checkValue("s4_winner", winner, 3);

    // Saturation from 5 on the damage-19 copy
    doReset();
    SpriteX = 10'd100; SpriteX2 = 10'd300; BallX = 10'd310; BallX2 = 10'd900;
    repeat (5) begin
      volley(1'b1, 1'b0);
      coolDown();
    end
    checkValue("s5_b_Health2_5", b_h2, 5);
    checkValue("s5_Health2_50", Health2, 50);
    volley(1'b1, 1'b0);
    checkValue("s5_b_pulse", b_bc, 1);
    checkValue("s5_b_Health2_0", b_h2, 0);
    step();
    checkValue("s5_b_ko", b_ko, 1);
    checkValue("s5_b_winner", b_win, 1);
    coolDown();
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    prevf = 1'b0;
    repeat (5) begin
      step();
      if (b_flying) prevf = 1'b1;
    end
    checkValue("s5_b_shot_ignored", prevf, 0);

    // Reset during flight
    doReset();
    SpriteX = 10'd100; SpriteX2 = 10'd400; BallX = 10'd500; BallX2 = 10'd110;
    volley(1'b0, 1'b1);
    checkValue("s6_Health_90", Health, 90);
    applyStimulus(1'b1, 1'b0, 10'd500, 10'd110);
    checkValue("s6_flying", flying, 1);
    applyStimulus(1'b1, 1'b0, 10'd500, 10'd110);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 10'd410, 10'd110);
    Reset = 1'b0;
    checkValue("s6_rst_flying", flying, 0);
    checkValue("s6_rst_Health", Health, 100);

    // Shoot held across the end of startscreen
    doReset();
    startscreen = 1'b1;
    applyStimulus(1'b1, 1'b0, 10'd500, 10'd110);
    applyStimulus(1'b1, 1'b0, 10'd500, 10'd110);
    startscreen = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd500, 10'd110);
    checkValue("s7_held_no_fire", flying, 0);

    // Randomized play against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 399) == 0);
      startscreen = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) shoot = ~shoot;
      if ($urandom_range(0, 7) == 0) shoot2 = ~shoot2;
      if ($urandom_range(0, 63) == 0) SpriteX = 10'($urandom_range(0, 600));
      if ($urandom_range(0, 63) == 0) SpriteX2 = 10'($urandom_range(0, 600));
      BallX = pickBall(SpriteX2);
      BallX2 = pickBall(SpriteX);
      step();
    end
    Reset = 1'b0;
    startscreen = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
